// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory between the IF stage
// (instruction fetch, read-only) and the MEM stage (load/store).
//
// Each transaction runs arbitrate -> address phase (req/gnt) -> response
// phase (rvalid), with one transaction outstanding at a time. The data
// port has fixed priority over the fetch port. A streak counter forces
// a fetch grant after MAX_DATA_STREAK data grants that were made while
// a fetch was waiting.
//
// Parameters:
//   DATA_WIDTH      data bus width
//   MAX_DATA_STREAK data grants allowed over a pending fetch (1..15)
//   PERF_CNT_WIDTH  width of the optional stall counters
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   instr_*               fetch port (req/addr in, gnt/rvalid/rdata out)
//   data_*                load/store port (req/we/be/addr/wdata in,
//                         gnt/rvalid/rdata out)
//   mem_*                 memory side (req/we/be/addr/wdata out,
//                         gnt/rvalid/rdata in)
//   perf_*_stall_o        cycles a request waited without a grant
//
// Optional feature macro: RISCV_ARB_PERF_CNT_EN
//   defined   -> saturating stall counters are built
//   undefined -> perf_*_stall_o are tied to 0, no counter flops

module riscv_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int PERF_CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,

  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,

  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic [PERF_CNT_WIDTH-1:0] perf_instr_stall_o,
  output logic [PERF_CNT_WIDTH-1:0] perf_data_stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t                  state;
  owner_t                  owner;
  logic [3:0]              streak;
  logic                    lat_we;
  logic [3:0]              lat_be;
  logic [31:0]             lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;

  logic arb_pt;
  logic force_instr;
  logic data_win;
  logic instr_win;

  // A new winner is picked when idle, or in the response cycle itself
  // so back-to-back transactions need no idle bubble.
  assign arb_pt = (state == IDLE) ||
                  ((state == RESP) && mem_rvalid_i);

  assign force_instr = instr_req_i && (streak == STREAK_MAX);
  assign data_win    = data_req_i && !force_instr;
  assign instr_win   = instr_req_i && !data_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner     <= OWN_INSTR;
      streak    <= 4'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= '0;
    end else if (arb_pt) begin
      if (data_win) begin
        state     <= REQ;
        owner     <= OWN_DATA;
        lat_we    <= data_we_i;
        lat_be    <= data_be_i;
        lat_addr  <= data_addr_i;
        lat_wdata <= data_wdata_i;
        // Only grants that overtake a waiting fetch extend the streak.
        streak    <= instr_req_i ? streak + 4'd1 : 4'd0;
      end else if (instr_win) begin
        state     <= REQ;
        owner     <= OWN_INSTR;
        lat_we    <= 1'b0;
        lat_be    <= 4'b1111;
        lat_addr  <= instr_addr_i;
        lat_wdata <= '0;
        streak    <= 4'd0;
      end else begin
        state     <= IDLE;
      end
    end else if (state == REQ) begin
      if (mem_gnt_i) begin
        state <= RESP;
      end
    end else if (state != RESP) begin
      state <= IDLE;
    end
  end

  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = lat_we;
  assign mem_be_o    = lat_be;
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;

  assign instr_gnt_o = mem_req_o && mem_gnt_i &&
                       (owner == OWN_INSTR);
  assign data_gnt_o  = mem_req_o && mem_gnt_i &&
                       (owner == OWN_DATA);

  assign instr_rvalid_o = (state == RESP) && mem_rvalid_i &&
                          (owner == OWN_INSTR);
  assign data_rvalid_o  = (state == RESP) && mem_rvalid_i &&
                          (owner == OWN_DATA);

  // Read data is passed straight through; rvalid qualifies it.
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;

`ifdef RISCV_ARB_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] instr_stall_q;
  logic [PERF_CNT_WIDTH-1:0] data_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_stall_q <= '0;
      data_stall_q  <= '0;
    end else begin
      if (instr_req_i && !instr_gnt_o && (instr_stall_q != '1)) begin
        instr_stall_q <= instr_stall_q + PERF_CNT_WIDTH'(1);
      end
      if (data_req_i && !data_gnt_o && (data_stall_q != '1)) begin
        data_stall_q <= data_stall_q + PERF_CNT_WIDTH'(1);
      end
    end
  end

  assign perf_instr_stall_o = instr_stall_q;
  assign perf_data_stall_o  = data_stall_q;
`else
  assign perf_instr_stall_o = '0;
  assign perf_data_stall_o  = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench for riscv_mem_arbiter.
// Requesters, a memory responder and a monitor run in one clocked process.

module tb_riscv_mem_arbiter;

  localparam int DW = 32;
  localparam int MS = 4;
  localparam int PW = 4;

  logic          clk_i;
  logic          rst_i;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic [PW-1:0] perf_instr_stall_o;
  logic [PW-1:0] perf_data_stall_o;

  riscv_mem_arbiter #(
    .DATA_WIDTH(DW),
    .MAX_DATA_STREAK(MS),
    .PERF_CNT_WIDTH(PW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .perf_instr_stall_o(perf_instr_stall_o),
    .perf_data_stall_o(perf_data_stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  txn_t sb_gnt[$];
  txn_t sb_resp[$];
  bit   glog[$];

  int errors;
  int checks;
  int igcnt;
  bit auto_mem;
  bit man_rvalid;
  int gnt_delay;
  int rv_delay;
  bit i_seen;
  bit d_seen;
  bit log_on;
  bit resp_pending;
  int gcnt;
  int rcnt;
  logic [31:0]   rd;
  logic [PW-1:0] m_pi;
  logic [PW-1:0] m_pd;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic txn_t mk(input logic d, input logic w,
                              input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] wd);
    txn_t t;
    t.is_data = d; t.we = w; t.be = b; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  always @(posedge clk_i) begin
    txn_t e;
    logic [31:0] got;
    #1;
    if (rst_i) begin
      iq.delete(); dq.delete(); sb_gnt.delete(); sb_resp.delete();
      i_seen = 0; d_seen = 0; resp_pending = 0; gcnt = 0;
    end
    if (i_seen && iq.size() > 0) void'(iq.pop_front());
    if (d_seen && dq.size() > 0) void'(dq.pop_front());
    i_seen = 0; d_seen = 0;
    instr_req_i = (iq.size() > 0);
    if (iq.size() > 0) instr_addr_i = iq[0].addr;
    data_req_i = (dq.size() > 0);
    if (dq.size() > 0) begin
      data_we_i = dq[0].we; data_be_i = dq[0].be;
      data_addr_i = dq[0].addr; data_wdata_i = dq[0].wdata;
    end
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    mem_rdata_i = $urandom;
    if (auto_mem) begin
      if (resp_pending) begin
        if (rcnt == 0) begin
          mem_rvalid_i = 1; mem_rdata_i = rd; resp_pending = 0;
        end else rcnt--;
      end else if (mem_req_o) begin
        if (gcnt >= gnt_delay) begin
          mem_gnt_i = 1; gcnt = 0; resp_pending = 1;
          rcnt = rv_delay; rd = rd_model(mem_addr_o);
        end else gcnt++;
      end
    end else if (man_rvalid) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; man_rvalid = 0;
    end
    #1;
    if (instr_gnt_o || data_gnt_o) begin
      checks++;
      if (instr_gnt_o && data_gnt_o) begin
        errors++;
        $display("FAIL gnt_excl: both gnts high");
      end
      checks++;
      if (sb_gnt.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexp: grant addr=%h, none expected",
                 mem_addr_o);
      end else begin
        e = sb_gnt.pop_front();
        if ({mem_req_o, data_gnt_o, mem_we_o, mem_be_o,
             mem_addr_o, mem_wdata_o} !==
            {1'b1, e.is_data, e.we, e.be, e.addr, e.wdata}) begin
          errors++;
          $display("FAIL gnt_txn: got d=%b we=%b be=%b a=%h wd=%h req=%b exp d=%b we=%b be=%b a=%h wd=%h",
                   data_gnt_o, mem_we_o, mem_be_o, mem_addr_o,
                   mem_wdata_o, mem_req_o, e.is_data, e.we, e.be,
                   e.addr, e.wdata);
        end
        sb_resp.push_back(e);
      end
      if (log_on) glog.push_back(data_gnt_o);
      if (instr_gnt_o) igcnt++;
      i_seen = instr_gnt_o;
      d_seen = data_gnt_o;
    end
    if (instr_rvalid_o || data_rvalid_o) begin
      checks++;
      if (sb_resp.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexp: rvalid i=%b d=%b, none expected",
                 instr_rvalid_o, data_rvalid_o);
      end else begin
        e = sb_resp.pop_front();
        got = e.is_data ? data_rdata_o : instr_rdata_o;
        if (data_rvalid_o !== e.is_data || instr_rvalid_o === e.is_data ||
            (!e.we && got !== rd_model(e.addr))) begin
          errors++;
          $display("FAIL resp: d=%b i=%b rdata=%h exp d=%b rdata=%h",
                   data_rvalid_o, instr_rvalid_o, got, e.is_data,
                   rd_model(e.addr));
        end
      end
    end
    checks++;
    if (perf_instr_stall_o !== m_pi || perf_data_stall_o !== m_pd) begin
      errors++;
      $display("FAIL perf: got i=%0d d=%0d exp i=%0d d=%0d",
               perf_instr_stall_o, perf_data_stall_o, m_pi, m_pd);
    end
`ifdef RISCV_ARB_PERF_CNT_EN
    if (rst_i) begin
      m_pi = '0; m_pd = '0;
    end else begin
      if (instr_req_i && !instr_gnt_o && m_pi != '1) m_pi = m_pi + 1'b1;
      if (data_req_i && !data_gnt_o && m_pd != '1) m_pd = m_pd + 1'b1;
    end
`endif
  end

  task automatic step();
    @(posedge clk_i);
    #3;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (iq.size() == 0 && dq.size() == 0 &&
          sb_gnt.size() == 0 && sb_resp.size() == 0 && !mem_req_o) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o,
         mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got req=%b we=%b be=%b a=%h wd=%h, exp all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    rst_i = 0;
    step();
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: mem_req_o=%b exp 0", mem_req_o);
    end
  endtask

  task automatic test_single_load();
    int base;
    bit ok;
    base = igcnt;
    sb_gnt.push_back(mk(1, 0, 4'hF, 32'h100, 0));
    dq.push_back(mk(1, 0, 4'hF, 32'h100, 0));
    step();
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL load_t0: mem_req_o=%b exp 0", mem_req_o);
    end
    step();
    checks++;
    if (mem_req_o !== 1'b1 || data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL load_t1: req=%b gnt=%b exp 1 1", mem_req_o, data_gnt_o);
    end
    step();
    checks++;
    if (data_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL load_t2: rvalid=%b exp 0", data_rvalid_o);
    end
    step();
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_t3: rvalid=%b rdata=%h exp 1 deadbeef",
               data_rvalid_o, data_rdata_o);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok || igcnt != base) begin
      errors++;
      $display("FAIL load_done: drained=%b instr_gnts=%0d exp 1 0",
               ok, igcnt - base);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit seen;
    seen = 0;
    sb_gnt.push_back(mk(1, 1, 4'b0011, 32'h200, 32'h1234));
    sb_gnt.push_back(mk(0, 0, 4'b1111, 32'h0, 0));
    dq.push_back(mk(1, 1, 4'b0011, 32'h200, 32'h1234));
    iq.push_back(mk(0, 0, 4'b1111, 32'h0, 0));
    for (int i = 0; i < 40; i++) begin
      step();
      if (seen) begin
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || mem_we_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b: req=%b addr=%h we=%b exp 1 0 0",
                   mem_req_o, mem_addr_o, mem_we_o);
        end
        break;
      end
      if (data_rvalid_o) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL simul_rvalid: data_rvalid seen=0 exp 1");
    end
    wait_drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL simul_done: drained=0 exp 1");
    end
  endtask

  task automatic test_starvation();
    bit ok;
    bit pat[10];
    int dn, in, s, di, ii;
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rv_delay = 0;
    glog.delete();
    log_on = 1;
    dn = 10; in = 10; s = 0; di = 0; ii = 0;
    while (dn > 0 || in > 0) begin
      if (dn > 0 && !(in > 0 && s == MS)) begin
        sb_gnt.push_back(mk(1, 0, 4'hF, 32'h1000 + 4 * di, 0));
        s = (in > 0) ? s + 1 : 0;
        dn--; di++;
      end else begin
        sb_gnt.push_back(mk(0, 0, 4'hF, 32'h2000 + 4 * ii, 0));
        s = 0;
        in--; ii++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      dq.push_back(mk(1, 0, 4'hF, 32'h1000 + 4 * i, 0));
      iq.push_back(mk(0, 0, 4'hF, 32'h2000 + 4 * i, 0));
    end
    wait_drain(200, ok);
    log_on = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL starve_done: drained=0 exp 1");
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= glog.size() || glog[i] !== pat[i]) begin
        errors++;
        $display("FAIL starve_seq[%0d]: got %0d exp %0d", i,
                 (i < glog.size()) ? int'(glog[i]) : -1, pat[i]);
      end
    end
    rv_delay = 1;
  endtask

  task automatic test_backpressure();
    bit ok;
    gnt_delay = 5;
    sb_gnt.push_back(mk(0, 0, 4'hF, 32'h40, 0));
    iq.push_back(mk(0, 0, 4'hF, 32'h40, 0));
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 ||
          instr_gnt_o !== (i == 5) || data_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL bp[%0d]: req=%b addr=%h ign=%b dgn=%b exp 1 40 %0d 0",
                 i, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o, i == 5);
      end
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_done: drained=0 exp 1");
    end
    gnt_delay = 0;
  endtask

  task automatic test_perf_sat();
    bit ok;
    logic [PW-1:0] exp_i;
`ifdef RISCV_ARB_PERF_CNT_EN
    exp_i = '1;
`else
    exp_i = '0;
`endif
    rst_i = 1;
    step();
    rst_i = 0;
    gnt_delay = 25;
    sb_gnt.push_back(mk(0, 0, 4'hF, 32'h80, 0));
    iq.push_back(mk(0, 0, 4'hF, 32'h80, 0));
    repeat (22) step();
    checks++;
    if (perf_instr_stall_o !== exp_i || perf_data_stall_o !== '0) begin
      errors++;
      $display("FAIL perf_sat: got i=%0d d=%0d exp i=%0d d=0",
               perf_instr_stall_o, perf_data_stall_o, exp_i);
    end
    wait_drain(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL perf_done: drained=0 exp 1");
    end
    gnt_delay = 0;
  endtask

  task automatic test_reset_midop();
    bit got;
    got = 0;
    rv_delay = 10;
    sb_gnt.push_back(mk(1, 0, 4'hF, 32'h300, 0));
    dq.push_back(mk(1, 0, 4'hF, 32'h300, 0));
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_gnt_o) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_gnt: data_gnt never seen");
    end
    auto_mem = 0;
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    man_rvalid = 1;
    step();
    checks++;
    if ({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o,
         mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0
        || mem_rvalid_i !== 1'b1) begin
      errors++;
      $display("FAIL rst_midop: rv_in=%b drv=%b irv=%b req=%b a=%h be=%b, exp 1 and all outs 0",
               mem_rvalid_i, data_rvalid_o, instr_rvalid_o, mem_req_o,
               mem_addr_o, mem_be_o);
    end
    step();
    checks++;
    if (mem_req_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: req=%b rvalid=%b exp 0 0",
               mem_req_o, data_rvalid_o);
    end
    auto_mem = 1;
    rv_delay = 1;
  endtask

  initial begin
    errors = 0; checks = 0; igcnt = 0;
    rst_i = 1;
    auto_mem = 1; man_rvalid = 0;
    gnt_delay = 0; rv_delay = 1;
    log_on = 0; resp_pending = 0; gcnt = 0; rcnt = 0; rd = '0;
    i_seen = 0; d_seen = 0;
    m_pi = '0; m_pd = '0;
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0;
    data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    test_reset();
    test_single_load();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_perf_sat();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each transaction as arbitrate, then address phase (req/gnt), then response phase (rvalid), with one transaction outstanding at a time.
- Data port has fixed priority over instruction port; a streak limiter prevents fetch starvation.
- Sits between the pipeline core and the memory/bus interface.

Parameters:
- DATA_WIDTH, 32, data bus width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while instr_req_i is pending before fetch is forced (legal range 1..15)
- PERF_CNT_WIDTH, 16, width of the stall counters (optional feature)

Ports:
- clk_i in 1: clock
- rst_i in 1: synchronous active-high reset
- instr_req_i in 1: fetch request; held with stable address until instr_gnt_o
- instr_addr_i in 32: fetch address
- instr_gnt_o out 1: fetch address phase accepted
- instr_rvalid_o out 1: fetch data valid
- instr_rdata_o out DATA_WIDTH: fetch data
- data_req_i in 1: load/store request; held stable until data_gnt_o
- data_we_i in 1: 1 = store
- data_be_i in 4: byte enables (SB/SH/SW)
- data_addr_i in 32: load/store address
- data_wdata_i in DATA_WIDTH: store data
- data_gnt_o out 1: load/store address phase accepted
- data_rvalid_o out 1: response valid (loads and stores)
- data_rdata_o out DATA_WIDTH: load data
- mem_req_o out 1: memory request
- mem_we_o out 1: memory write enable
- mem_be_o out 4: memory byte enables
- mem_addr_o out 32: memory address
- mem_wdata_o out DATA_WIDTH: memory write data
- mem_gnt_i in 1: memory accepted request
- mem_rvalid_i in 1: memory response valid (returned for writes too)
- mem_rdata_i in DATA_WIDTH: memory read data
- perf_instr_stall_o out PERF_CNT_WIDTH: optional, see below
- perf_data_stall_o out PERF_CNT_WIDTH: optional, see below

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- State machine: IDLE, REQ, RESP. Registers: owner (INSTR/DATA), latched request fields, streak counter (4 bits).
- Arbitration point: IDLE, or RESP in the cycle mem_rvalid_i=1. Winner selection:
  - data wins if data_req_i=1, unless instr_req_i=1 and streak==MAX_DATA_STREAK, in which case instr wins;
  - otherwise instr wins if instr_req_i=1;
  - if no requests, go to (or stay in) IDLE.
- Winner handling: winner's we/be/addr/wdata are latched (instr: we=0, be=4'b1111, wdata=0), owner is set, and the next state is REQ.
- Streak counter:
  - data grant while instr_req_i=1: streak+1;
  - instr grant: streak cleared;
  - data grant with instr_req_i=0: streak cleared.
- REQ state:
  - mem_req_o=1 and mem_* are driven from the latched registers.
  - {owner}_gnt_o = mem_gnt_i (combinational; 0 for the non-owner).
  - On mem_gnt_i=1, go to RESP; otherwise stay in REQ holding all outputs.
- RESP state:
  - mem_req_o=0.
  - {owner}_rvalid_o = mem_rvalid_i.
  - On mem_rvalid_i=1, arbitrate again: back-to-back transactions go RESP to REQ with no IDLE bubble.
- Latency:
  - requester req at cycle t gives mem_req_o at t+1 (from IDLE), or at t+1 after rvalid (back-to-back);
  - gnt with zero added latency;
  - rvalid with zero added latency.
- instr_rdata_o and data_rdata_o: continuous copies of mem_rdata_i; consumers qualify with rvalid.
- mem_rvalid_i in IDLE or REQ, and mem_gnt_i outside REQ: ignored; no output changes.
- A requester that re-asserts req during RESP is considered only at the rvalid arbitration point.
- Reset values: state=IDLE, owner=INSTR, streak=0, latched fields=0. All gnt/rvalid/mem_req_o/mem_we_o outputs are 0; mem_be_o/mem_addr_o/mem_wdata_o are 0; perf counters are 0.
- Reset mid-transaction: the outstanding transaction is abandoned; a rvalid arriving after reset is ignored (state IDLE).

Optional Feature:
- Macro: RISCV_ARB_PERF_CNT_EN.
- Defined:
  - perf_instr_stall_o / perf_data_stall_o count cycles where the respective req_i=1 and gnt_o=0;
  - counters saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Single load: data_req_i=1, data_addr_i=0x100, mem_gnt_i=1 immediately, mem_rvalid_i=1 two cycles later with rdata=0xDEADBEEF -> mem_req_o=1 at t+1, data_gnt_o=1 at t+1, data_rvalid_o=1 with data_rdata_o=0xDEADBEEF, instr_gnt_o never asserted.
- Simultaneous requests, streak=0: instr (addr 0x0) and data store (addr 0x200, be=4'b0011, wdata=0x1234) in the same cycle -> data served first with mem_we_o=1, mem_be_o=4'b0011; instr served next, back-to-back with no IDLE cycle.
- Starvation: data_req_i and instr_req_i held high continuously, MAX_DATA_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Gnt backpressure: mem_gnt_i held 0 for 5 cycles during a fetch at 0x40 -> mem_req_o/mem_addr_o=0x40 stable for 6 cycles, instr_gnt_o=1 only in the 6th, data_gnt_o=0 throughout (perf_data_stall_o increments if the macro is defined and data_req_i=1).
- Reset mid-op: rst_i=1 in RESP, mem_rvalid_i=1 one cycle after reset deasserts -> no rvalid_o asserted, all outputs 0, state IDLE.
- Perf saturation (macro defined, PERF_CNT_WIDTH=4): instr_req_i held ungranted for 20 cycles -> perf_instr_stall_o stops at 15.
